demo_scene_sequencer: RTL and testbench

Frame-level controller for the demo output pins. Generates 640x480@60 VGA timing (25.175 MHz nominal clk) and sequences the demo through a fixed ring of scenes. Each scene runs for a programmed number of frames, followed by a blanked gap. The pixel datapath consumes scene, scene_frame, hpos, vpos and blank_active; this block never produces pixel colour itself.

---
 rtl/demokit_pkg.sv | 22 ++
 rtl/vga_timing.sv | 57 +++++
 rtl/demo_scene_sequencer.sv | 112 +++++++++++
 tb/tb_demo_scene_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demokit_pkg.sv
// Shared VGA timing constants and sequencer state type for the demo output block.
// 640x480@60 timing: visible, front porch, sync and back porch per axis.
package demokit_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  typedef enum logic {
    RUN,
    BLANK
  } seq_state_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus zero-latency sync/visible/frame decodes.
// frame_edge is high during the last pixel, so the next edge wraps to (0,0).
module vga_timing
  import demokit_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       frame_start,
  output logic       frame_edge
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SW - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SW - 1);

  logic line_end;

  assign line_end   = (hpos == H_LAST);
  assign frame_edge = line_end && (vpos == V_LAST);

  // NOTE: reset is synchronous; rst must be high across a rising edge of clk to take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
    end else if (line_end) begin
      // NOTE: state uses <= so every flop in this block samples pre-edge values.
      hpos <= '0;
      vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos <= hpos + 10'd1;
    end
  end

  assign hsync       = !((hpos >= HS_FIRST) && (hpos <= HS_LAST));
  assign vsync       = !((vpos >= VS_FIRST) && (vpos <= VS_LAST));
  assign display_on  = (hpos < 10'(H_VIS)) && (vpos < 10'(V_VIS));
  assign frame_start = (hpos == 10'd0) && (vpos == 10'd0);

endmodule

// File: rtl/demo_scene_sequencer.sv
// Demo frame controller: VGA raster plus a ring of timed scenes separated by blanked gaps.
// Scene state changes only on the frame edge, so it is stable for a whole frame.
module demo_scene_sequencer
  import demokit_pkg::*;
#(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 240,
  parameter int BLANK_FRAMES = 8,
  parameter int H_VIS        = H_VISIBLE,
  parameter int H_FP         = H_FRONT,
  parameter int H_SW         = H_SYNC,
  parameter int H_BP         = H_BACK,
  parameter int V_VIS        = V_VISIBLE,
  parameter int V_FP         = V_FRONT,
  parameter int V_SW         = V_SYNC,
  parameter int V_BP         = V_BACK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        pause,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic        frame_start,
  output logic [2:0]  scene,
  output logic [7:0]  scene_frame,
  output logic        blank_active,
  output logic [15:0] frame_count
);

  localparam logic [7:0] RUN_LAST   = 8'(SCENE_FRAMES - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES - 1);
  localparam logic [2:0] SCENE_LAST = 3'(NUM_SCENES - 1);

  logic       frame_edge;
  logic       btn_meta;
  logic       btn_sync;
  logic       btn_prev;
  logic       btn_rise;
  logic       pending;
  seq_state_t state;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .frame_start(frame_start),
    .frame_edge (frame_edge)
  );

  assign btn_rise = btn_sync && !btn_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta     <= 1'b0;
      btn_sync     <= 1'b0;
      btn_prev     <= 1'b0;
      pending      <= 1'b0;
      state        <= RUN;
      scene        <= '0;
      scene_frame  <= '0;
      blank_active <= 1'b0;
      frame_count  <= '0;
    end else begin
      // btn_next is an unsynchronised pin: two flops before it is trusted.
      btn_meta <= btn_next;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;

      if (frame_edge) begin
        frame_count <= frame_count + 16'd1;
        // The old request is consumed here; a rise seen on this same cycle waits a frame.
        pending     <= btn_rise;
        case (state)
          RUN: begin
            if (pending || (!pause && scene_frame == RUN_LAST)) begin
              state        <= BLANK;
              scene_frame  <= '0;
              blank_active <= 1'b1;
            end else if (!pause) begin
              scene_frame <= scene_frame + 8'd1;
            end
          end
          BLANK: begin
            if (scene_frame == BLANK_LAST) begin
              state        <= RUN;
              scene        <= (scene == SCENE_LAST) ? 3'd0 : scene + 3'd1;
              scene_frame  <= '0;
              blank_active <= 1'b0;
            end else begin
              scene_frame <= scene_frame + 8'd1;
            end
          end
          default: state <= RUN;
        endcase
      end else if (btn_rise) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Bench for demo_scene_sequencer: real-timing line checks, a fixed scene-ring sequence,
// and a randomized scoreboard run on a shrunken raster against a frame-level model.
module tb_demo_scene_sequencer;
  import demokit_pkg::*;

  // Shrunken raster for the sequencer instances: 25 x 12 = 300 clocks per frame.
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int R_N = 3, R_SF = 3, R_BF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- randomized scoreboard instance ----------------
  logic rst_r = 1'b0, btn_r = 1'b0, pause_r = 1'b0;
  logic [9:0] hpos_r, vpos_r;
  logic hsync_r, vsync_r, de_r, fs_r, blank_r;
  logic [2:0] scene_r;
  logic [7:0] sf_r;
  logic [15:0] fc_r;

  demo_scene_sequencer #(
    .NUM_SCENES(R_N), .SCENE_FRAMES(R_SF), .BLANK_FRAMES(R_BF),
    .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)
  ) u_rand (
    .clk(clk), .rst(rst_r), .btn_next(btn_r), .pause(pause_r),
    .hpos(hpos_r), .vpos(vpos_r), .hsync(hsync_r), .vsync(vsync_r),
    .display_on(de_r), .frame_start(fs_r), .scene(scene_r),
    .scene_frame(sf_r), .blank_active(blank_r), .frame_count(fc_r)
  );

  typedef struct {
    int scene;
    int sf;
    int blank;
    int fc;
  } exp_t;

  exp_t sb_q[$];
  int m_scene, m_sf, m_blank, m_fc, m_carry;

  function automatic void model_reset();
    m_scene = 0; m_sf = 0; m_blank = 0; m_fc = 0; m_carry = 0;
    sb_q.delete();
    sb_q.push_back('{0, 0, 0, 0});
  endfunction

  // Applies the scene rules for one frame edge and queues the next frame's outputs.
  function automatic void model_edge(input bit pz, input bit req);
    m_fc = (m_fc + 1) % 65536;
    if (m_blank == 0) begin
      if (req || (!pz && m_sf == R_SF - 1)) begin
        m_blank = 1; m_sf = 0;
      end else if (!pz) begin
        m_sf++;
      end
    end else if (m_sf == R_BF - 1) begin
      m_blank = 0; m_sf = 0; m_scene = (m_scene + 1) % R_N;
    end else begin
      m_sf++;
    end
    sb_q.push_back('{m_scene, m_sf, m_blank, m_fc});
  endfunction

  // Monitor: tracks raster position independently, pops expectations at each frame start.
  int   mpos = 0;
  bit   armed = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;

  always @(posedge clk) begin
    logic r;
    int h, v;
    r = rst_r;
    #1;
    if (r) begin
      armed = 1'b1;
      mpos  = 0;
    end else begin
      mpos = (mpos + 1) % FT;
    end
    if (armed) begin
      h = mpos % HT;
      v = mpos / HT;
      check("timing", {8'd0, hpos_r, vpos_r, hsync_r, vsync_r, de_r, fs_r},
            {8'd0, 10'(h), 10'(v), !(h >= HV + HF && h < HV + HF + HS),
             !(v >= VV + VF && v < VV + VF + VS), (h < HV && v < VV), (h == 0 && v == 0)});
      if (h == 0 && v == 0) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          cur      = sb_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur)
        check("seq_state", {4'd0, scene_r, sf_r, blank_r, fc_r},
              {4'd0, 3'(cur.scene), 8'(cur.sf), 1'(cur.blank), 16'(cur.fc)});
    end
  end

  task automatic reset_rand();
    btn_r = 1'b0;
    model_reset();
    rst_r = 1'b1;
    @(negedge clk);
    rst_r = 1'b0;
  endtask

  // One frame from raster position 0. press: 0 none, 1 mid-frame, 2 rise on the frame edge.
  task automatic rand_frame(input bit pz, input int press, input int rst_at);
    pause_r = pz;
    for (int i = 0; i < FT; i++) begin
      if (i == rst_at) begin
        reset_rand();
        return;
      end
      btn_r = (press == 1) ? (i >= 100 && i < 103) :
              (press == 2) ? (i >= FT - 3) : 1'b0;
      if (i == FT - 1) begin
        model_edge(pz, (m_carry != 0) || (press == 1));
        m_carry = (press == 2) ? 1 : 0;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- ring instance: 2 scenes, 2 run frames, 1 blank frame ----------------
  logic rst_g = 1'b0;
  logic [9:0] hpos_g, vpos_g;
  logic hsync_g, vsync_g, de_g, fs_g, blank_g;
  logic [2:0] scene_g;
  logic [7:0] sf_g;
  logic [15:0] fc_g;

  demo_scene_sequencer #(
    .NUM_SCENES(2), .SCENE_FRAMES(2), .BLANK_FRAMES(1),
    .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)
  ) u_ring (
    .clk(clk), .rst(rst_g), .btn_next(1'b0), .pause(1'b0),
    .hpos(hpos_g), .vpos(vpos_g), .hsync(hsync_g), .vsync(vsync_g),
    .display_on(de_g), .frame_start(fs_g), .scene(scene_g),
    .scene_frame(sf_g), .blank_active(blank_g), .frame_count(fc_g)
  );

  // ---------------- full-size instance for real 640x480 line timing ----------------
  logic rst_f = 1'b0;
  logic [9:0] hpos_f, vpos_f;
  logic hsync_f, vsync_f, de_f, fs_f, blank_f;
  logic [2:0] scene_f;
  logic [7:0] sf_f;
  logic [15:0] fc_f;

  demo_scene_sequencer u_full (
    .clk(clk), .rst(rst_f), .btn_next(1'b0), .pause(1'b0),
    .hpos(hpos_f), .vpos(vpos_f), .hsync(hsync_f), .vsync(vsync_f),
    .display_on(de_f), .frame_start(fs_f), .scene(scene_f),
    .scene_frame(sf_f), .blank_active(blank_f), .frame_count(fc_f)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt, first_low, tries;
    int ring_scene[7];
    int ring_blank[7];
    ring_scene = '{0, 0, 0, 1, 1, 1, 0};
    ring_blank = '{0, 0, 1, 0, 0, 1, 0};

    // Full-size raster: reset values and two lines of horizontal timing.
    @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    check("full_reset_pos", {12'd0, hpos_f, vpos_f}, 32'd0);
    check("full_reset_decode", {28'd0, hsync_f, vsync_f, de_f, fs_f}, 32'hF);
    check("full_reset_seq", {4'd0, scene_f, sf_f, blank_f, fc_f}, 32'd0);
    low_cnt   = 0;
    first_low = -1;
    for (int c = 1; c <= 2 * H_TOTAL; c++) begin
      @(negedge clk);
      if (!hsync_f) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
      if (c == H_VISIBLE) check("full_de_off_at_640", 32'(de_f), 32'd0);
      if (c == H_TOTAL) check("full_line_wrap", {12'd0, hpos_f, vpos_f}, {12'd0, 10'd0, 10'd1});
    end
    check("full_hsync_low_clocks", 32'(low_cnt), 32'(2 * H_SYNC));
    check("full_hsync_first_low", 32'(first_low), 32'(H_VISIBLE + H_FRONT));

    // Fixed scene ring with no buttons: wrap 1 -> 0 and single-frame blank.
    rst_g = 1'b1;
    @(negedge clk);
    rst_g = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("ring_frame_start", {hpos_g, vpos_g, fs_g}, {10'd0, 10'd0, 1'b1});
      check("ring_scene_blank", {scene_g, blank_g}, {3'(ring_scene[k]), 1'(ring_blank[k])});
      check("ring_frame_count", 32'(fc_g), 32'(k));
      repeat (FT) @(negedge clk);
    end

    // Scoreboard run: directed scenarios first, then random frames, then reset mid-BLANK.
    reset_rand();
    rand_frame(1'b0, 0, -1);
    repeat (5) rand_frame(1'b1, 0, -1);
    rand_frame(1'b1, 1, -1);
    rand_frame(1'b0, 1, -1);
    rand_frame(1'b0, 0, -1);
    rand_frame(1'b0, 0, -1);
    rand_frame(1'b0, 0, -1);
    rand_frame(1'b0, 1, -1);
    rand_frame(1'b0, 0, -1);
    rand_frame(1'b0, 0, -1);
    rand_frame(1'b0, 2, -1);
    rand_frame(1'b0, 0, -1);
    for (int f = 0; f < 50; f++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rand_frame($urandom_range(0, 3) == 0, (sel < 6) ? 0 : (sel < 8) ? 1 : 2, -1);
    end
    tries = 0;
    while (m_blank == 0 && tries < 20) begin
      rand_frame(1'b0, 0, -1);
      tries++;
    end
    check("reached_blank", 32'(m_blank), 32'd1);
    rand_frame(1'b0, 0, 3 * HT + 12);
    rand_frame(1'b0, 0, -1);
    rand_frame(1'b0, 1, -1);
    rand_frame(1'b0, 0, -1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
